// File: rtl/bounce_hit_detector.sv
// bounce_hit_detector
//   Two-axis bounce detector. Tracks the raster position from the timing
//   strobes, samples the ball video bit against the four screen edges
//   (with a MARGIN-wide zone) and, once per frame at i_VReset, updates the
//   X/Y directions, emits one-cycle hit pulses and a saturating hit count.
//   Optional macro BOUNCE_CORNER_EN adds o_Corner / o_CornerSeen.
module bounce_hit_detector #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned MARGIN    = 0,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_HReset,
    input  logic                 i_HBlank,
    input  logic                 i_VReset,
    input  logic                 i_VBlank,
    input  logic                 i_Ball,
    output logic                 o_XDir,
    output logic                 o_YDir,
    output logic                 o_HitX,
    output logic                 o_HitY,
    output logic [CNT_WIDTH-1:0] o_HitCount
`ifdef BOUNCE_CORNER_EN
    ,
    output logic                 o_Corner,
    output logic                 o_CornerSeen
`endif
);

    localparam int unsigned CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(MARGIN);
    localparam logic [CW-1:0] COL_HI   = CW'(H_ACTIVE - 1 - MARGIN);
    localparam logic [LW-1:0] LINE_LO  = LW'(MARGIN);
    localparam logic [LW-1:0] LINE_HI  = LW'(V_ACTIVE - 1 - MARGIN);

    logic [CW-1:0] col_q, cur_col;
    logic [LW-1:0] line_q, cur_line;
    logic          flag_l, flag_r, flag_t, flag_b;
    logic          pix_valid;
    logic          hit_l, hit_r, hit_t, hit_b;
    logic          flip_x, flip_y;

    // Position of the current pixel: the registers hold the previous cycle's
    // position, so strobes and increments are applied combinationally here
    // to give the pixel sampled this cycle its exact column/line.
    always_comb begin
        cur_col  = col_q;
        cur_line = line_q;
        if (i_HReset)
            cur_col = '0;
        else if (!i_HBlank && col_q != COL_MAX)
            cur_col = col_q + 1'b1;
        if (i_VReset)
            cur_line = '0;
        else if (i_HReset && !i_VBlank && line_q != LINE_MAX)
            cur_line = line_q + 1'b1;

        pix_valid = !i_HBlank && !i_VBlank;
        hit_l = pix_valid && i_Ball && (cur_col  <= COL_LO);
        hit_r = pix_valid && i_Ball && (cur_col  >= COL_HI);
        hit_t = pix_valid && i_Ball && (cur_line <= LINE_LO);
        hit_b = pix_valid && i_Ball && (cur_line >= LINE_HI);

        // Direction-qualified: only flip when moving toward the touched edge.
        flip_x = (flag_l && !flag_r && !o_XDir) || (flag_r && !flag_l && o_XDir);
        flip_y = (flag_t && !flag_b && !o_YDir) || (flag_b && !flag_t && o_YDir);
    end

    // Raster position registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            col_q  <= '0;
            line_q <= '0;
        end else begin
            col_q  <= cur_col;
            line_q <= cur_line;
        end
    end

    // Sticky edge-contact flags; restarted at the frame boundary with only
    // the i_VReset cycle's own pixel.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            flag_l <= 1'b0;
            flag_r <= 1'b0;
            flag_t <= 1'b0;
            flag_b <= 1'b0;
        end else if (i_VReset) begin
            flag_l <= hit_l;
            flag_r <= hit_r;
            flag_t <= hit_t;
            flag_b <= hit_b;
        end else begin
            flag_l <= flag_l | hit_l;
            flag_r <= flag_r | hit_r;
            flag_t <= flag_t | hit_t;
            flag_b <= flag_b | hit_b;
        end
    end

    // Once-per-frame evaluation: directions, hit pulses, saturating count.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_XDir     <= 1'b1;
            o_YDir     <= 1'b1;
            o_HitX     <= 1'b0;
            o_HitY     <= 1'b0;
            o_HitCount <= '0;
        end else if (i_VReset) begin
            o_XDir <= o_XDir ^ flip_x;
            o_YDir <= o_YDir ^ flip_y;
            o_HitX <= flip_x;
            o_HitY <= flip_y;
            if ((flip_x || flip_y) && o_HitCount != '1)
                o_HitCount <= o_HitCount + 1'b1;
        end else begin
            o_HitX <= 1'b0;
            o_HitY <= 1'b0;
        end
    end

`ifdef BOUNCE_CORNER_EN
    // Corner pulse alongside the hit pulses, plus a sticky seen flag.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Corner     <= 1'b0;
            o_CornerSeen <= 1'b0;
        end else if (i_VReset) begin
            o_Corner     <= flip_x && flip_y;
            o_CornerSeen <= o_CornerSeen || (flip_x && flip_y);
        end else begin
            o_Corner     <= 1'b0;
        end
    end
`endif

endmodule
